// File: rtl/vec_seq_pkg.sv
// Shared definitions for the vec_mul job sequencer: FSM state encoding and
// the default array timing constants also used by the datapath top.
package vec_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    // Default address widths
    localparam int DEF_ADDRESSSIZE = 10;
    localparam int DEF_WADDR_BW    = 2;

    // Cycles from ub_valid to the matching result on the array output
    localparam int DEF_LAT         = 33;

    // Cycles weight_reload is held: one SRAM read plus one array latch
    localparam int DEF_WLOAD_CYC   = 2;

endpackage

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
// valid_delay_line: DEPTH-stage 1-bit shift register that carries the
// activation valid bit forward to the result-write side of the array.
// dout is the last stage. empty is registered and is high once no live
// row sits behind the output stage, i.e. the line holds nothing after the
// current output leaves. This lets the controller leave DRAIN in the same
// cycle as the final write. DEPTH must be at least 2.
module valid_delay_line #(
    parameter int DEPTH = 33
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout,
    output logic empty
);

    logic [DEPTH-1:0] sr;
    logic [DEPTH-1:0] sr_next;

    assign sr_next = {sr[DEPTH-2:0], din};
    assign dout    = sr[DEPTH-1];

    // Shift the valid bit each cycle; track whether any row is still in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sr    <= '0;
            empty <= 1'b1;
        end else begin
            sr    <= sr_next;
            empty <= ~|sr_next[DEPTH-2:0];
        end
    end

endmodule

// File: rtl/vec_mul_sequencer.sv
// vec_mul_sequencer: sequences one vector-multiply job on the vec_mul
// datapath. It loads a weight tile, streams row_count activation rows from
// the unified buffer and writes each result LAT cycles later.
//
// Handshake: start is a single-cycle request. It is accepted only in IDLE,
// and the job configuration is latched at that point. While busy=1, start
// is ignored and never queued. done pulses for one cycle when a job ends,
// and a new start is accepted in the following cycle.
// ub_valid=1 marks ub_addr as a live row for this cycle. res_we=1 marks
// res_addr as the write target for the result on the array output this cycle.
//
// Optional feature: define VEC_SEQ_PERF_EN to add perf_cycles, a saturating
// 16-bit count of busy cycles.
module vec_mul_sequencer
    import vec_seq_pkg::*;
#(
    parameter int ADDRESSSIZE = DEF_ADDRESSSIZE,
    parameter int WADDR_BW    = DEF_WADDR_BW,
    parameter int LAT         = DEF_LAT,
    parameter int WLOAD_CYC   = DEF_WLOAD_CYC
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic [ADDRESSSIZE-1:0] row_count,
    input  logic [WADDR_BW-1:0]    wtile,
    output logic [WADDR_BW-1:0]    weight_addr,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   ub_valid,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr,
    output logic                   busy,
    output logic                   done
`ifdef VEC_SEQ_PERF_EN
    ,
    output logic [15:0]            perf_cycles
`endif
);

    localparam int WL_W = (WLOAD_CYC > 1) ? $clog2(WLOAD_CYC) : 1;
    localparam logic [WL_W-1:0] WL_LAST = WL_W'(WLOAD_CYC - 1);

    seq_state_e state;
    seq_state_e state_n;

    logic                   accept;
    logic [ADDRESSSIZE-1:0] ub_base_q;
    logic [ADDRESSSIZE-1:0] res_base_q;
    logic [ADDRESSSIZE-1:0] row_count_q;
    logic [ADDRESSSIZE-1:0] ub_base_n;
    logic [ADDRESSSIZE-1:0] res_base_n;
    logic [ADDRESSSIZE-1:0] row_count_n;
    logic [ADDRESSSIZE-1:0] row_cnt;
    logic [ADDRESSSIZE-1:0] row_cnt_n;
    logic [ADDRESSSIZE-1:0] wr_cnt;
    logic [ADDRESSSIZE-1:0] wr_cnt_n;
    logic [WL_W-1:0]        wl_cnt;
    logic [WL_W-1:0]        wl_cnt_n;

    logic                   busy_n;
    logic                   done_n;
    logic                   weight_reload_n;
    logic [WADDR_BW-1:0]    weight_addr_n;
    logic                   ub_valid_n;
    logic [ADDRESSSIZE-1:0] ub_addr_n;
    logic [ADDRESSSIZE-1:0] res_addr_n;

    logic                   dl_dout;
    logic                   dl_empty;

    assign accept = (state == IDLE) && start;
    assign res_we = dl_dout;

    valid_delay_line #(
        .DEPTH (LAT)
    ) u_delay (
        .clk   (clk),
        .rstn  (rstn),
        .din   (ub_valid),
        .dout  (dl_dout),
        .empty (dl_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (row_count == '0) ? DONE : WLOAD;
            WLOAD:   if (wl_cnt == WL_LAST) state_n = STREAM;
            STREAM:  if (row_cnt == row_count_q - ADDRESSSIZE'(1)) state_n = DRAIN;
            DRAIN:   if (dl_empty) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the job configuration and the load/row/write counters
    always_comb begin
        ub_base_n   = accept ? ub_base   : ub_base_q;
        res_base_n  = accept ? res_base  : res_base_q;
        row_count_n = accept ? row_count : row_count_q;
        wl_cnt_n    = (state == WLOAD) ? wl_cnt + WL_W'(1) : '0;
        row_cnt_n   = row_cnt;
        wr_cnt_n    = wr_cnt;
        if (accept) begin
            row_cnt_n = '0;
            wr_cnt_n  = '0;
        end else begin
            if (state == STREAM) row_cnt_n = row_cnt + ADDRESSSIZE'(1);
            if (dl_dout)         wr_cnt_n  = wr_cnt + ADDRESSSIZE'(1);
        end
    end

    // Configuration latches and counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ub_base_q   <= '0;
            res_base_q  <= '0;
            row_count_q <= '0;
            row_cnt     <= '0;
            wr_cnt      <= '0;
            wl_cnt      <= '0;
        end else begin
            ub_base_q   <= ub_base_n;
            res_base_q  <= res_base_n;
            row_count_q <= row_count_n;
            row_cnt     <= row_cnt_n;
            wr_cnt      <= wr_cnt_n;
            wl_cnt      <= wl_cnt_n;
        end
    end

    // Output decode from the upcoming state, so the registered outputs line up with it
    always_comb begin
        busy_n          = (state_n != IDLE);
        done_n          = (state_n == DONE);
        weight_reload_n = (state_n == WLOAD);
        ub_valid_n      = (state_n == STREAM);
        weight_addr_n   = accept ? wtile : weight_addr;
        ub_addr_n       = ub_base_n + row_cnt_n;
        res_addr_n      = res_base_n + wr_cnt_n;
    end

    // Output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            weight_reload <= 1'b0;
            weight_addr   <= '0;
            ub_valid      <= 1'b0;
            ub_addr       <= '0;
            res_addr      <= '0;
        end else begin
            busy          <= busy_n;
            done          <= done_n;
            weight_reload <= weight_reload_n;
            weight_addr   <= weight_addr_n;
            ub_valid      <= ub_valid_n;
            ub_addr       <= ub_addr_n;
            res_addr      <= res_addr_n;
        end
    end

`ifdef VEC_SEQ_PERF_EN
    // Busy-cycle counter: cleared on accepted start, saturates, holds after done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cycles <= '0;
        end else if (accept) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 16'hFFFF)) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer (LAT=33, WLOAD_CYC=2).
// Cycle 0 is the cycle in which start is driven; all sampling happens on
// the falling edge, where every registered output is stable.
// Define VEC_SEQ_PERF_EN to also exercise perf_cycles.
module tb_vec_mul_sequencer;

    localparam int AW  = 10;
    localparam int WW  = 2;
    localparam int LAT = 33;
    localparam int WLC = 2;
    localparam int VW  = 27;

    logic          clk;
    logic          rstn;
    logic          start;
    logic [AW-1:0] ub_base;
    logic [AW-1:0] res_base;
    logic [AW-1:0] row_count;
    logic [WW-1:0] wtile;
    logic [WW-1:0] weight_addr;
    logic          weight_reload;
    logic [AW-1:0] ub_addr;
    logic          ub_valid;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic          busy;
    logic          done;
`ifdef VEC_SEQ_PERF_EN
    logic [15:0]   perf_cycles;
`endif

    int checks = 0;
    int passed = 0;
    logic [VW-1:0] exp_q[$];

    vec_mul_sequencer dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .ub_base       (ub_base),
        .res_base      (res_base),
        .row_count     (row_count),
        .wtile         (wtile),
        .weight_addr   (weight_addr),
        .weight_reload (weight_reload),
        .ub_addr       (ub_addr),
        .ub_valid      (ub_valid),
        .res_we        (res_we),
        .res_addr      (res_addr),
        .busy          (busy),
        .done          (done)
`ifdef VEC_SEQ_PERF_EN
        ,
        .perf_cycles   (perf_cycles)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected output vector in cycle c of a job
    // {busy, done, weight_reload, weight_addr, ub_valid, ub_addr, res_we, res_addr}
    // with addresses shown only while their strobe is high.
    function automatic logic [VW-1:0] model(input int c, input int n,
                                            input logic [AW-1:0] ub,
                                            input logic [AW-1:0] rb,
                                            input logic [WW-1:0] wt);
        int dc;
        logic b, d, r, v, w;
        logic [WW-1:0] wa;
        logic [AW-1:0] ua, ra;
        dc = (n == 0) ? 1 : WLC + n + LAT + 1;
        b  = (c >= 1) && (c <= dc);
        d  = (c == dc);
        r  = (n != 0) && (c >= 1) && (c <= WLC);
        v  = (n != 0) && (c >= WLC + 1) && (c <= WLC + n);
        w  = (n != 0) && (c >= WLC + 1 + LAT) && (c <= WLC + n + LAT);
        wa = r ? wt : '0;
        ua = v ? ub + AW'(c - WLC - 1) : '0;
        ra = w ? rb + AW'(c - WLC - 1 - LAT) : '0;
        return {b, d, r, wa, v, ua, w, ra};
    endfunction

    function automatic logic [VW-1:0] observed();
        return {busy, done, weight_reload,
                weight_reload ? weight_addr : 2'b00,
                ub_valid, ub_valid ? ub_addr : 10'h000,
                res_we, res_we ? res_addr : 10'h000};
    endfunction

    // Driver: called at the falling edge of cycle 0, returns in cycle 1
    task automatic start_job(input logic [AW-1:0] ub, input logic [AW-1:0] rb,
                             input logic [AW-1:0] n, input logic [WW-1:0] wt);
        ub_base   = ub;
        res_base  = rb;
        row_count = n;
        wtile     = wt;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic fill_exp(input int last, input int n, input logic [AW-1:0] ub,
                            input logic [AW-1:0] rb, input logic [WW-1:0] wt);
        exp_q.delete();
        for (int c = 1; c <= last; c++) exp_q.push_back(model(c, n, ub, rb, wt));
    endtask

    task automatic test_reset();
        logic [VW+2:0] raw;
        rstn = 1'b1; start = 1'b0;
        ub_base = '0; res_base = '0; row_count = '0; wtile = '0;
        #1 rstn = 1'b0;
        #1;
        raw = {busy, done, weight_reload, weight_addr, ub_valid, ub_addr, res_we, res_addr, 3'b000};
        checks++;
        if (raw !== '0) $display("FAIL reset_outputs: got %h expected 0", raw);
        else passed++;
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd0) $display("FAIL reset_perf: got %0d expected 0", perf_cycles);
        else passed++;
`endif
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, res_we} !== 3'b000) $display("FAIL reset_idle cycle %0d: got %b expected 000", c, {busy, done, res_we});
            else passed++;
        end
    endtask

    task automatic test_basic();
        logic [VW-1:0] got, e;
        fill_exp(41, 4, 10'h010, 10'h200, 2'd1);
        start_job(10'h010, 10'h200, 10'd4, 2'd1);
        for (int c = 1; c <= 41; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL basic cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 41) @(negedge clk);
        end
        checks++;
        if (weight_addr !== 2'd1) $display("FAIL basic_wtile_hold: got %0d expected 1", weight_addr);
        else passed++;
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd40) $display("FAIL basic_perf: got %0d expected 40", perf_cycles);
        else passed++;
`endif
    endtask

    task automatic test_zero_rows();
        logic [VW-1:0] got, e;
        fill_exp(3, 0, 10'h055, 10'h155, 2'd3);
        start_job(10'h055, 10'h155, 10'd0, 2'd3);
        for (int c = 1; c <= 3; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL zero_rows cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 3) @(negedge clk);
        end
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd1) $display("FAIL zero_perf: got %0d expected 1", perf_cycles);
        else passed++;
`endif
    endtask

    task automatic test_wrap();
        logic [VW-1:0] got, e;
        fill_exp(41, 4, 10'h3FE, 10'h3FD, 2'd2);
        start_job(10'h3FE, 10'h3FD, 10'd4, 2'd2);
        for (int c = 1; c <= 41; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL wrap cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 41) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [VW-1:0] got, e;
        fill_exp(41, 4, 10'h040, 10'h100, 2'd2);
        start_job(10'h040, 10'h100, 10'd4, 2'd2);
        for (int c = 1; c <= 41; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL ignore_start cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            start = (c == 5) || (c == 20);
            if (start) begin
                ub_base   = 10'h155;
                res_base  = 10'h000;
                row_count = 10'd7;
                wtile     = 2'd3;
            end
            if (c != 41) @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        logic [VW-1:0] got, e;
        logic [VW+2:0] raw;
        fill_exp(19, 8, 10'h080, 10'h300, 2'd3);
        start_job(10'h080, 10'h300, 10'd8, 2'd3);
        for (int c = 1; c <= 19; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset_mid pre cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        raw = {busy, done, weight_reload, weight_addr, ub_valid, ub_addr, res_we, res_addr, 3'b000};
        checks++;
        if (raw !== '0) $display("FAIL reset_mid_async: got %h expected 0", raw);
        else passed++;
        for (int c = 21; c <= 80; c++) begin
            @(negedge clk);
            if (c == 22) rstn = 1'b1;
            checks++;
            if ({busy, done, res_we, ub_valid} !== 4'b0000)
                $display("FAIL reset_mid_quiet cycle %0d: got %b expected 0000", c, {busy, done, res_we, ub_valid});
            else passed++;
        end
        fill_exp(40, 3, 10'h005, 10'h005, 2'd0);
        start_job(10'h005, 10'h005, 10'd3, 2'd0);
        for (int c = 1; c <= 40; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset_mid_restart cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 40) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] got, e;
        fill_exp(41, 4, 10'h0A0, 10'h1A0, 2'd1);
        start_job(10'h0A0, 10'h1A0, 10'd4, 2'd1);
        for (int c = 1; c <= 41; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL b2b_first cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 41) @(negedge clk);
        end
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd40) $display("FAIL b2b_perf_first: got %0d expected 40", perf_cycles);
        else passed++;
`endif
        // Cycle 41 of the first job is cycle 0 of the second
        fill_exp(39, 2, 10'h3FF, 10'h3FF, 2'd2);
        start_job(10'h3FF, 10'h3FF, 10'd2, 2'd2);
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd0) $display("FAIL b2b_perf_clear: got %0d expected 0", perf_cycles);
        else passed++;
`endif
        for (int c = 1; c <= 39; c++) begin
            got = observed();
            e   = exp_q.pop_front();
            checks++;
            if (got !== e) $display("FAIL b2b_second cycle %0d: got %h expected %h", c, got, e);
            else passed++;
            if (c != 39) @(negedge clk);
        end
`ifdef VEC_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 16'd38) $display("FAIL b2b_perf_second: got %0d expected 38", perf_cycles);
        else passed++;
`endif
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_basic();
        test_zero_rows();
        test_wrap();
        test_ignore_start();
        test_reset_mid_job();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
